// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI clock generator.
package spi_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    TRAIL = 2'd2
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Half-period down-counter: ticks when it reaches zero while running, then reloads.
module spi_halfper_cnt
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '1;
    end else if (load || tick) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master SCLK generator with CPOL/CPHA modes, trailing hold half-period
// and one-cycle sample/shift strobes for the shift register.
//
// state | meaning
// IDLE  | sclk follows cpol_i, waiting for start
// RUN   | toggling sclk, one toggle per half-period tick, 2N edges
// TRAIL | sclk parked at cpol for one half-period, then done
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic [DIV_W-1:0] divider_i,
  input  logic [CNT_W-1:0] nbits_i,
  output logic             sclk_o,
  output logic             sample_o,
  output logic             shift_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  state_t           state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [CNT_W:0]   edge_q, edge_d, edge_nxt;
  logic             sclk_q, sclk_d, sample_q, sample_d, shift_q, shift_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic             start_ok, cnt_load, cnt_run, tick, leading, last_edge;
  logic [DIV_W-1:0] cnt_val;

  // A start seen while done_o is showing belongs to the finished transfer.
  assign start_ok  = start_i && en_i && !done_q;
  assign cnt_load  = (state_q == IDLE) && start_ok;
  assign cnt_run   = (state_q != IDLE) && en_i;
  assign cnt_val   = (state_q == IDLE) ? divider_i : div_q;
  assign edge_nxt  = edge_q + 1'b1;
  assign leading   = edge_nxt[0];
  assign last_edge = (edge_nxt == {nbits_q, 1'b0});

  spi_halfper_cnt #(.DIV_W(DIV_W)) u_halfper_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (cnt_load),
    .run      (cnt_run),
    .load_val (cnt_val),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    sample_d  = 1'b0;
    shift_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        if (start_ok) begin
          mode_d.cpol = cpol_i;
          mode_d.cpha = cpha_i;
          div_d       = divider_i;
          nbits_d     = nbits_i;
          edge_d      = '0;
          bit_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = (nbits_i == '0) ? TRAIL : RUN;
        end
      end
      RUN: begin
        if (!en_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sclk_d  = cpol_i;
        end else if (tick) begin
          sclk_d   = ~sclk_q;
          edge_d   = edge_nxt;
          sample_d = mode_q.cpha ? ~leading : leading;
          shift_d  = mode_q.cpha ? leading : (~leading && !last_edge);
          if (sample_d) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (last_edge) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (!en_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sclk_d  = cpol_i;
        end else begin
          sclk_d = mode_q.cpol;
          if (tick) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      div_q     <= '0;
      nbits_q   <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign sample_o  = sample_q;
  assign shift_o   = shift_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: elapsed-time reference model checked every cycle,
// directed transfers with literal expectations, then randomized traffic.
module tb_spi_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, start, cpol, cpha;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             sclk_o, sample_o, shift_o, busy_o, done_o;
  logic [CNT_W-1:0] bit_cnt_o;

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .start_i   (start),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .divider_i (div),
    .nbits_i   (nbits),
    .sclk_o    (sclk_o),
    .sample_o  (sample_o),
    .shift_o   (shift_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .bit_cnt_o (bit_cnt_o)
  );

  always #5 clk = ~clk;

  int     pass_cnt = 0;
  int     total_cnt = 0;
  longint cyc = 0;

  // Reference model: everything inside a transfer follows from the time elapsed
  // since the accepting edge t0; value "visible at" t0+o was registered at t0+o-1.
  logic   m_valid = 1'b0, m_active = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
  longint m_D = 0, m_N = 0, m_t0 = 0, m_o, m_kk, m_kc, m_hp;
  logic   m_prev_done;
  logic   e_sclk = 1'b0, e_sample = 1'b0, e_shift = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  int     e_bits = 0;

  always @(posedge clk) begin
    cyc++;
    m_prev_done = e_done;
    e_sample = 1'b0;
    e_shift  = 1'b0;
    e_done   = 1'b0;
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      e_sclk   = 1'b0;
      e_busy   = 1'b0;
      e_bits   = 0;
    end else if (m_valid) begin
      if (m_active && !en) begin
        m_active = 1'b0;
        e_busy   = 1'b0;
        e_sclk   = cpol;
      end else if (m_active) begin
        m_hp = m_D + 1;
        m_o  = cyc + 1 - m_t0;
        if (m_o == 1 + (2 * m_N + 1) * m_hp) begin
          e_done   = 1'b1;
          e_busy   = 1'b0;
          m_active = 1'b0;
          e_sclk   = m_cpol;
        end else begin
          e_busy = 1'b1;
          m_kk   = (m_o - 1) / m_hp;
          m_kc   = (m_kk > 2 * m_N) ? 2 * m_N : m_kk;
          e_sclk = m_cpol ^ (m_kc % 2 == 1);
          if ((m_o - 1) % m_hp == 0 && m_kk >= 1 && m_kk <= 2 * m_N) begin
            if (m_cpha) begin
              e_shift  = (m_kk % 2 == 1);
              e_sample = (m_kk % 2 == 0);
            end else begin
              e_sample = (m_kk % 2 == 1);
              e_shift  = (m_kk % 2 == 0) && (m_kk != 2 * m_N);
            end
          end
          if (e_sample) e_bits++;
        end
      end else begin
        e_sclk = cpol;
        e_busy = 1'b0;
        if (start && en && !m_prev_done) begin
          m_active = 1'b1;
          m_t0     = cyc;
          m_cpol   = cpol;
          m_cpha   = cpha;
          m_D      = longint'(div);
          m_N      = longint'(nbits);
          e_bits   = 0;
          e_busy   = 1'b1;
        end
      end
    end
  end

  int     n_samp = 0, n_shift = 0, n_tog = 0, n_done = 0;
  longint done_cyc = 0;
  logic   prev_sclk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("sclk_o",    32'(sclk_o),    32'(e_sclk));
        check("sample_o",  32'(sample_o),  32'(e_sample));
        check("shift_o",   32'(shift_o),   32'(e_shift));
        check("busy_o",    32'(busy_o),    32'(e_busy));
        check("done_o",    32'(done_o),    32'(e_done));
        check("bit_cnt_o", 32'(bit_cnt_o), 32'(e_bits));
      end
      if (sample_o === 1'b1) n_samp++;
      if (shift_o === 1'b1) n_shift++;
      if (done_o === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (sclk_o !== prev_sclk) n_tog++;
      prev_sclk = sclk_o;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (n_done == d0 && k < 3000) begin
      step(1);
      k++;
    end
    check({tag, " done_seen"}, 32'(n_done - d0), 32'd1);
  endtask

  task automatic run_xfer(input string tag, input logic p, input logic h, input int d, input int n,
                          input int x_off, input int x_samp, input int x_shift, input int x_tog);
    int s_samp, s_shift, s_tog, s_done;
    longint t0;
    step(1);
    en = 1'b1; start = 1'b0; cpol = p; cpha = h;
    div = DIV_W'(d); nbits = CNT_W'(n);
    step(1);
    s_samp = n_samp; s_shift = n_shift; s_tog = n_tog; s_done = n_done;
    start = 1'b1;
    t0 = cyc + 1;
    step(1);
    start = 1'b0;
    cpol = 1'($urandom); cpha = 1'($urandom);
    div = DIV_W'($urandom); nbits = CNT_W'($urandom);
    wait_done(s_done, tag);
    check({tag, " done_offset"}, 32'(done_cyc + 1 - t0), 32'(x_off));
    check({tag, " samples"},     32'(n_samp - s_samp),   32'(x_samp));
    check({tag, " shifts"},      32'(n_shift - s_shift), 32'(x_shift));
    check({tag, " toggles"},     32'(n_tog - s_tog),     32'(x_tog));
    check({tag, " bit_cnt"},     32'(bit_cnt_o),         32'(x_samp));
  endtask

  task automatic stimulus();
    int s_tog, s_done, k;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    div = '0; nbits = '0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset sclk_o", 32'(sclk_o), 32'd0);

    run_xfer("mode0 d0 n1", 1'b0, 1'b0, 0,   1, 4,   1, 0, 2);
    run_xfer("mode3 d3 n8", 1'b1, 1'b1, 3,   8, 69,  8, 8, 16);
    run_xfer("mode1 d1 n2", 1'b0, 1'b1, 1,   2, 11,  2, 2, 4);
    run_xfer("n0 d2",       1'b0, 1'b0, 2,   0, 4,   0, 0, 0);
    run_xfer("mode0 d2 n3", 1'b0, 1'b0, 2,   3, 22,  3, 2, 6);
    run_xfer("mode2 dmax",  1'b1, 1'b0, 255, 1, 769, 1, 0, 2);

    // abort after edge 3 of a 4-bit transfer, with stray start pulses mid-transfer
    step(1);
    en = 1'b1; cpol = 1'b1; cpha = 1'b0; div = DIV_W'(1); nbits = CNT_W'(4);
    step(1);
    s_tog = n_tog; s_done = n_done;
    start = 1'b1;
    step(1);
    k = 0;
    while (n_tog - s_tog < 3 && k < 100) begin
      start = 1'($urandom);
      step(1);
      k++;
    end
    check("abort edge3 reached", 32'(n_tog - s_tog), 32'd3);
    start = 1'b0; en = 1'b0;
    step(1);
    check("abort busy_o", 32'(busy_o), 32'd0);
    check("abort sclk_o", 32'(sclk_o), 32'd1);
    step(20);
    check("abort no done", 32'(n_done - s_done), 32'd0);

    // start held high through done: ignored in the done cycle, taken one later
    en = 1'b1; cpol = 1'b0; cpha = 1'b0; div = '0; nbits = CNT_W'(1);
    step(1);
    s_done = n_done;
    start = 1'b1;
    wait_done(s_done, "held start");
    step(1);
    check("held start ignored in done cycle", 32'(busy_o), 32'd0);
    step(1);
    check("held start restart", 32'(busy_o), 32'd1);
    start = 1'b0;
    wait_done(s_done + 1, "held start second");

    // synchronous reset mid-RUN
    cpol = 1'b1; cpha = 1'b1; div = DIV_W'(2); nbits = CNT_W'(5);
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("sync reset busy_o",    32'(busy_o),    32'd0);
    check("sync reset sclk_o",    32'(sclk_o),    32'd0);
    check("sync reset bit_cnt_o", 32'(bit_cnt_o), 32'd0);

    // reset glitch between edges must not disturb a running transfer
    step(1);
    s_done = n_done;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(1);
    check("reset glitch busy_o", 32'(busy_o), 32'd1);
    wait_done(s_done, "reset glitch");

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 5) == 0);
      cpol  = 1'($urandom);
      cpha  = 1'($urandom);
      div   = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 15))
                                          : DIV_W'($urandom_range(0, 3));
      nbits = CNT_W'($urandom);
      step(1);
    end
    rst_n = 1'b1; en = 1'b1; start = 1'b0;
    step(3);
  endtask

  initial begin
    fork
      monitor_loop();
      stimulus();
    join_any
    disable fork;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
